matvec_sequencer: RTL

Control-side companion to the 8-lane MAC array: it accepts a streamed operand sequence (one shared B element plus N per-lane A elements per beat) and drives the array's clear, enable and operand inputs. It waits out the array latency, captures the N accumulated results, and streams them out one lane per beat. It sits between the operand source (DMA/FIFO) and the result sink, turning the array into a start/done matrix-vector engine.

---
 rtl/matvec_pkg.sv | 20 ++
 rtl/matvec_sequencer_result_drain.sv | 47 ++++
 rtl/matvec_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// Shared types and default widths for the matrix-vector sequencer slice.
package matvec_pkg;

  localparam int unsigned DFLT_DATA_WIDTH = 8;
  localparam int unsigned DFLT_N          = 8;
  localparam int unsigned DFLT_K_MAX      = 255;

  localparam int unsigned ACC_W = 3 * DFLT_DATA_WIDTH;
  localparam int unsigned KW    = $clog2(DFLT_K_MAX + 1);
  localparam int unsigned IW    = $clog2(DFLT_N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/matvec_sequencer_result_drain.sv
// Result capture buffer and indexed valid/ready output stage for the sequencer.
module result_drain
  import matvec_pkg::*;
#(
  parameter int unsigned N     = DFLT_N,
  parameter int unsigned RES_W = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic                 active,
  input  logic [RES_W-1:0]     acc [0:N-1],
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [RES_W-1:0]     res_data,
  output logic [$clog2(N)-1:0] res_idx,
  output logic                 res_last,
  output logic                 last_hs
);

  localparam int unsigned LIW = $clog2(N);

  logic [RES_W-1:0] res_buf [0:N-1];
  logic [LIW-1:0]   idx;

  // Buffer is deliberately left out of reset; outputs are gated by active.
  always_ff @(posedge clk) begin
    if (capture) res_buf <= acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (capture) begin
      idx <= '0;
    end else if (active && res_ready) begin
      idx <= res_last ? '0 : idx + LIW'(1);
    end
  end

  assign res_valid = active;
  assign res_last  = active && (idx == LIW'(N - 1));
  assign last_hs   = res_last && res_ready;
  assign res_idx   = idx;
  assign res_data  = active ? res_buf[idx] : '0;

endmodule

// File: rtl/matvec_sequencer.sv
// Start/done sequencer for the N-lane MAC array: clear, feed, wait, drain.
// Optional MATVEC_SEQ_PERF_EN adds a 16-bit saturating stall counter port.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int unsigned N          = DFLT_N,
  parameter int unsigned K_MAX      = DFLT_K_MAX,
  parameter int unsigned MAC_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATA_WIDTH-1:0]         op_b,
  input  logic [DATA_WIDTH-1:0]         op_a [0:N-1],
  output logic                          mac_en,
  output logic                          mac_clr,
  output logic [DATA_WIDTH-1:0]         mac_b,
  output logic [DATA_WIDTH-1:0]         mac_a [0:N-1],
  input  logic [3*DATA_WIDTH-1:0]       mac_c [0:N-1],
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [3*DATA_WIDTH-1:0]       res_data,
  output logic [$clog2(N)-1:0]          res_idx,
  output logic                          res_last,
  output logic                          busy,
  output logic                          done
`ifdef MATVEC_SEQ_PERF_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int unsigned CW    = 3 * DATA_WIDTH;
  localparam int unsigned LKW   = $clog2(K_MAX + 1);
  localparam int unsigned LAT_W = $clog2(MAC_LAT + 1);

  state_t           state;
  logic [LKW-1:0]   k_lat;
  logic [LKW-1:0]   k_eff;
  logic [LKW-1:0]   beat_cnt;
  logic [LAT_W-1:0] wait_cnt;
  logic             capture;
  logic             drain_last_hs;

  assign op_ready = (state == S_FEED);
  assign mac_en   = op_valid && op_ready;
  assign mac_clr  = (state == S_CLEAR);
  assign busy     = (state != S_IDLE);
  assign capture  = (state == S_WAIT) && (wait_cnt == LAT_W'(MAC_LAT - 1));

  // Operands reach the array only while feeding so idle outputs stay at zero.
  always_comb begin
    mac_b = op_ready ? op_b : '0;
    for (int unsigned i = 0; i < N; i++) begin
      mac_a[i] = op_ready ? op_a[i] : '0;
    end
  end

  always_comb begin
    k_eff = k_len;
    if ({1'b0, k_len} > (LKW+1)'(K_MAX)) k_eff = LKW'(K_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k_lat    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_lat    <= k_eff;
            beat_cnt <= '0;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          wait_cnt <= '0;
          state    <= (k_lat != '0) ? S_FEED : S_WAIT;
        end
        S_FEED: begin
          if (mac_en) begin
            if (beat_cnt == k_lat - LKW'(1)) begin
              beat_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              beat_cnt <= beat_cnt + LKW'(1);
            end
          end
        end
        S_WAIT: begin
          if (capture) state <= S_DRAIN;
          else         wait_cnt <= wait_cnt + LAT_W'(1);
        end
        S_DRAIN: begin
          if (drain_last_hs) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  result_drain #(
    .N     (N),
    .RES_W (CW)
  ) u_drain (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .active    (state == S_DRAIN),
    .acc       (mac_c),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last),
    .last_hs   (drain_last_hs)
  );

`ifdef MATVEC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (((state == S_FEED) && !op_valid) || ((state == S_DRAIN) && !res_ready)) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
